// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL lock sequencer: default timing parameters,
//   the FSM state encoding (also driven onto the debug 'state' port) and small
//   constant helpers used to size the shared cycle counter.
package pll_seq_pkg;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_RELEASE_GAP_CYCLES  = 64;
  localparam int DEF_MAX_RETRIES         = 3;

  // Encoding is fixed so the debug port reads the same in every build.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_REL0      = 3'd3,
    ST_REL1      = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    return max2(max2(a, b), max2(c, d));
  endfunction

  // Counter only has to reach (largest period - 1).
  function automatic int cnt_width(input int largest);
    return (largest <= 2) ? 1 : $clog2(largest);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   Ports:
//     clk - destination clock (rising edge)
//     rst - synchronous active-high reset, clears both flops
//     d   - asynchronous input level
//     q   - synchronized level, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Pulses the PLL reset, waits for a qualified lock (with bounded retries),
//   then releases the outclk_0 reset followed RELEASE_GAP_CYCLES later by the
//   outclk_1 reset. Lock loss after release re-asserts both resets and restarts.
//   Ports:
//     refclk       - free-running reference clock, all logic on rising edge
//     rst          - synchronous active-high reset
//     pll_locked   - PLL lock indication, asynchronous (synchronized here)
//     soft_restart - single-cycle request; restarts from PLL reset, clears
//                    retry_count, lock_lost and fault. Wins over all else.
//     pll_rst      - active-high PLL reset
//     rst_out_0    - active-high reset for outclk_0 domain
//     rst_out_1    - active-high reset for outclk_1 domain
//     ready        - high only in RUN
//     fault        - high only in FAULT
//     lock_lost    - sticky: lock dropped after stable qualification
//     retry_count  - lock-timeout retries since last RUN entry / restart
//     state        - FSM state encoding (debug)
//   All outputs are registered; they change only on the refclk edge after the
//   condition is sampled.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_restart,
  output logic       pll_rst,
  output logic       rst_out_0,
  output logic       rst_out_1,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int CNT_W = cnt_width(max4(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                        LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES));

  // Terminal counts: the counter starts at 0 on phase entry, so the last
  // cycle of an N-cycle phase is N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic locked_s;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_rst_q, pll_rst_d;
  logic             rst_out_0_q, rst_out_0_d;
  logic             rst_out_1_q, rst_out_1_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (soft_restart) begin
      state_d     = ST_PLL_RST;
      cnt_d       = '0;
      retry_d     = 4'd0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        ST_STABLE: begin
          cnt_d = cnt_q + 1'b1;
          // A drop restarts the lock wait without consuming a retry.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_REL0;
            cnt_d   = '0;
          end
        end
        ST_REL0, ST_REL1, ST_RUN: begin
          if (!locked_s) begin
            state_d     = ST_PLL_RST;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
          end else if (state_q == ST_REL0) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) begin
              state_d = ST_REL1;
              cnt_d   = '0;
            end
          end else if (state_q == ST_REL1) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs decode the next state so they are registered alongside it and
    // never glitch. rst_out_1 releases only in a subset of rst_out_0's states.
    pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    rst_out_0_d = !((state_d == ST_REL0) || (state_d == ST_REL1) || (state_d == ST_RUN));
    rst_out_1_d = !((state_d == ST_REL1) || (state_d == ST_RUN));
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_out_0_q <= 1'b1;
      rst_out_1_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_0_q <= rst_out_0_d;
      rst_out_1_q <= rst_out_1_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out_0   = rst_out_0_q;
  assign rst_out_1   = rst_out_1_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Drives directed scenarios and random lock/restart/reset traffic. Every
//   drive steps a phase/elapsed-time reference model and queues the expected
//   output vector; a monitor pops and compares after each rising edge.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int P_RST  = 4;
  localparam int P_TO   = 32;
  localparam int P_STB  = 8;
  localparam int P_GAP  = 4;
  localparam int P_MAXR = 2;
  localparam int W      = 13;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       soft_restart;
  logic       pll_rst;
  logic       rst_out_0;
  logic       rst_out_1;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .LOCK_STABLE_CYCLES  (P_STB),
    .RELEASE_GAP_CYCLES  (P_GAP),
    .MAX_RETRIES         (P_MAXR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_restart (soft_restart),
    .pll_rst      (pll_rst),
    .rst_out_0    (rst_out_0),
    .rst_out_1    (rst_out_1),
    .ready        (ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .state        (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;

  // directed-check tokens handed from stimulus to the monitor
  string dir_name = "";
  int    dir_got  = 0;
  int    dir_exp  = 0;
  int    dir_req  = 0;
  int    dir_seen = 0;

  // observations made by the monitor
  int   r0_fall    = -1;
  int   r1_fall    = -1;
  int   prst_rises = 0;
  logic prev_r0    = 1'b1;
  logic prev_r1    = 1'b1;
  logic prev_prst  = 1'b1;
  logic [W-1:0] act_v;
  logic [W-1:0] exp_v;

  // ---------------- reference model ----------------
  // Phase name plus cycles spent in it; lock is seen two cycles late.
  string m_ph = "PLL_RST";
  int    m_t = 0;
  int    m_retries = 0;
  bit    m_lost = 0;
  bit    m_dly[$];

  function automatic logic [2:0] ph_code(input string p);
    if (p == "PLL_RST")   return ST_PLL_RST;
    if (p == "WAIT_LOCK") return ST_WAIT_LOCK;
    if (p == "STABLE")    return ST_STABLE;
    if (p == "REL0")      return ST_REL0;
    if (p == "REL1")      return ST_REL1;
    if (p == "RUN")       return ST_RUN;
    return ST_FAULT;
  endfunction

  task automatic enter(input string p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit lk);
    bit ls;
    if (r) begin
      enter("PLL_RST");
      m_retries = 0;
      m_lost    = 0;
      m_dly.delete();
      m_dly.push_back(1'b0);
      m_dly.push_back(1'b0);
    end else begin
      ls = m_dly.pop_front();
      m_dly.push_back(lk);
      if (s) begin
        enter("PLL_RST");
        m_retries = 0;
        m_lost    = 0;
      end else if (m_ph == "PLL_RST") begin
        m_t++;
        if (m_t == P_RST) enter("WAIT_LOCK");
      end else if (m_ph == "WAIT_LOCK") begin
        if (ls) enter("STABLE");
        else begin
          m_t++;
          if (m_t == P_TO) begin
            if (m_retries == P_MAXR) enter("FAULT");
            else begin
              m_retries++;
              enter("PLL_RST");
            end
          end
        end
      end else if (m_ph == "STABLE") begin
        if (!ls) enter("WAIT_LOCK");
        else begin
          m_t++;
          if (m_t == P_STB) enter("REL0");
        end
      end else if ((m_ph == "REL0" || m_ph == "REL1" || m_ph == "RUN") && !ls) begin
        enter("PLL_RST");
        m_lost = 1;
      end else if (m_ph == "REL0") begin
        m_t++;
        if (m_t == P_GAP) enter("REL1");
      end else if (m_ph == "REL1") begin
        enter("RUN");
        m_retries = 0;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    bit pr;
    bit rel0;
    bit rel1;
    pr   = (m_ph == "PLL_RST") || (m_ph == "FAULT");
    rel0 = (m_ph == "REL0") || (m_ph == "REL1") || (m_ph == "RUN");
    rel1 = (m_ph == "REL1") || (m_ph == "RUN");
    return {pr, !rel0, !rel1, (m_ph == "RUN"), (m_ph == "FAULT"), m_lost,
            4'(m_retries), ph_code(m_ph)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit s, input bit lk);
    @(negedge refclk);
    rst          = r;
    soft_restart = s;
    pll_locked   = lk;
    last_edge    = cyc + 1;
    model_step(r, s, lk);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input bit lk, input int n);
    repeat (n) drive(1'b0, 1'b0, lk);
  endtask

  task automatic directed(input string n, input int got, input int expv);
    dir_name = n;
    dir_got  = got;
    dir_exp  = expv;
    dir_req++;
    drive(1'b0, 1'b0, pll_locked);
  endtask

  // ---------------- monitor ----------------
  always @(posedge refclk) begin
    cyc++;
    #1;
    act_v = {pll_rst, rst_out_0, rst_out_1, ready, fault, lock_lost, retry_count, state};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d got %h expected %h (pll_rst,r0,r1,ready,fault,lost,retry[4],state[3])",
                 cyc, act_v, exp_v);
      end
    end
    if (dir_req != dir_seen) begin
      dir_seen = dir_req;
      checks++;
      if (dir_got != dir_exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", dir_name, dir_got, dir_exp);
      end
    end
    if (prev_r0 && !rst_out_0) r0_fall = cyc;
    if (prev_r1 && !rst_out_1) r1_fall = cyc;
    if (!prev_prst && pll_rst && !fault) prst_rises++;
    prev_r0   = rst_out_0;
    prev_r1   = rst_out_1;
    prev_prst = pll_rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    int rise_e;
    int base;
    bit found;
    rst          = 1'b1;
    soft_restart = 1'b0;
    pll_locked   = 1'b0;

    // reset
    repeat (3) drive(1'b1, 1'b0, 1'b0);

    // clean lock, lock arrives ~10 cycles after release
    hold(1'b0, 9);
    hold(1'b1, 1);
    rise_e = last_edge;
    hold(1'b1, 30);
    directed("rst_out_0_latency", r0_fall - rise_e, 10);
    directed("rst_out_1_gap", r1_fall - r0_fall, P_GAP);
    directed("ready_in_run", ready, 1);

    // never locks: three pulses then FAULT, held
    base = prst_rises;
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b0, 130);
    directed("pll_rst_pulses", prst_rises - base, 3);
    directed("fault_held", fault, 1);

    // restart out of FAULT, then lock
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b0, 6);
    hold(1'b1, 30);

    // lock loss in RUN, then relock
    hold(1'b0, 8);
    hold(1'b1, 40);

    // glitch during STABLE
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b0, 6);
    hold(1'b1, 5);
    hold(1'b0, 6);
    hold(1'b1, 30);

    // soft_restart in the cycle the loss is seen
    hold(1'b0, 2);
    drive(1'b0, 1'b1, 1'b0);
    directed("lock_lost_after_soft", lock_lost, 0);
    hold(1'b1, 30);

    // rst during REL1
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b0, 6);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (m_ph == "REL1") found = 1;
    end
    if (found) drive(1'b1, 1'b0, 1'b1);
    directed("reached_rel1", found, 1);
    hold(1'b1, 30);

    // random traffic
    for (int seg = 0; seg < 80; seg++) begin
      bit lk;
      int len;
      lk  = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 45);
      for (int k = 0; k < len; k++) begin
        drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0), lk);
      end
    end

    hold(pll_locked, 3);
    @(posedge refclk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: pll_rst pulse length in refclk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum wait for lock after a pll_rst pulse.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before any release.
REQ-004 SHALL have parameter RELEASE_GAP_CYCLES, default 64: cycles between rst_out_0 release and rst_out_1 release.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: timeout retries allowed before fault.
REQ-006 refclk  in  1  sole clock, free-running board reference; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 pll_locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-009 soft_restart  in  1  single-cycle request to restart the full sequence.
REQ-010 pll_rst  out  1  active-high reset to the PLL.
REQ-011 rst_out_0  out  1  active-high reset for the outclk_0 (60 MHz) domain; resynchronized downstream.
REQ-012 rst_out_1  out  1  active-high reset for the outclk_1 (1 MHz) domain; resynchronized downstream.
REQ-013 ready  out  1  high only in RUN.
REQ-014 fault  out  1  high only in FAULT.
REQ-015 lock_lost  out  1  sticky flag: lock dropped after the stable qualification.
REQ-016 retry_count  out  4  timeout retries since the last RUN entry or restart.
REQ-017 state  out  3  current FSM state encoding, for debug.

Function
REQ-018 pll_locked SHALL pass through a 2-flop synchronizer; locked_s lags pll_locked by 2 cycles, and only locked_s is used internally.
REQ-019 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE, REL0, REL1, RUN and FAULT, with a single shared down/up counter sized by $clog2 of the largest parameter.
REQ-020 PLL_RST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK with the counter cleared.
REQ-021 WAIT_LOCK: when locked_s=1 -> STABLE with the counter cleared.
REQ-022 WAIT_LOCK timeout: after LOCK_TIMEOUT_CYCLES cycles without lock, if retry_count==MAX_RETRIES -> FAULT, else increment retry_count and go to PLL_RST.
REQ-023 STABLE: after LOCK_STABLE_CYCLES consecutive cycles of locked_s=1 -> REL0; a drop of locked_s -> WAIT_LOCK with the timeout counter cleared and retry_count unchanged.
REQ-024 REL0: rst_out_0=0; after RELEASE_GAP_CYCLES cycles -> REL1.
REQ-025 REL1: rst_out_1=0 -> RUN on the next cycle; retry_count is cleared on RUN entry.
REQ-026 Lock loss: locked_s=0 in REL0, REL1 or RUN SHALL drive rst_out_0=rst_out_1=1 and ready=0 on the next cycle, set lock_lost, and go to PLL_RST.
REQ-027 FAULT: pll_rst=1, rst_out_0=1, rst_out_1=1; the only exits are soft_restart or rst.
REQ-028 soft_restart SHALL take priority over every other transition in any state: -> PLL_RST, with retry_count, lock_lost and fault cleared and both rst_out asserted.
REQ-029 rst_out_0 and rst_out_1 SHALL be registered, glitch-free, and 1 in every state except as stated in REQ-024 and REQ-025.
REQ-030 rst_out_1 SHALL never be 0 while rst_out_0 is 1.

Reset
REQ-031 On rst=1, the next-cycle values SHALL be: state=PLL_RST, counter=0, pll_rst=1, rst_out_0=1, rst_out_1=1, ready=0, fault=0, lock_lost=0, retry_count=0, synchronizer flops=0.
REQ-032 rst asserted in any state, including mid-REL1, SHALL override all FSM activity.

Structure
REQ-033 Package pll_seq_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-034 The synchronizer SHALL be a sub-module named sync_2ff, instantiated once.

Verification (RST_PULSE=4, TIMEOUT=32, STABLE=8, GAP=4, MAX_RETRIES=2)
REQ-035 Clean lock: rst released, pll_locked=1 at cycle 10 and held -> pll_rst high for 4 cycles; rst_out_0 falls 10 cycles after pll_locked rises; rst_out_1 falls 4 cycles later; ready=1; retry_count=0.
REQ-036 Never locks -> exactly 3 pll_rst pulses, then fault=1, retry_count=2, and all resets held high indefinitely.
REQ-037 Glitch: locked high for 5 cycles then low during STABLE -> no release, return to WAIT_LOCK, retry_count unchanged.
REQ-038 Loss in RUN: pll_locked drops -> 2 cycles later both rst_out=1, ready=0, lock_lost=1, followed by a 4-cycle pll_rst pulse.
REQ-039 soft_restart in FAULT -> fault=0, retry_count=0, pll_rst pulse of 4 cycles; soft_restart arriving in the same cycle as a lock loss -> lock_lost remains 0.
REQ-040 rst asserted during REL1 -> all outputs at their REQ-031 values on the next cycle.
